pipeif_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the IF/ID pipeline register.
- Owns the program counter, the next-PC selection (sequential/branch/register-jump/jump) and the instruction-memory handshake.
- Presents pc4/ins/ins_valid to the IF/ID register combinationally each cycle.
- Tolerates multi-cycle instruction memory and ID-stage stalls; delay-slot semantics are preserved.

---
 rtl/pipeif_fetch.sv | 134 +++++++++++++
 tb/tb_pipeif_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection with one-entry redirect buffer,
// and multi-cycle instruction-memory handshake with a HOLD buffer for ID-stage stalls.
module pipeif_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        wpcir,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] ins,
   output logic        ins_valid
);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] hold_q, hold_d;

   logic        redirect_s;
   logic [31:0] target_s;
   logic [31:0] pc4_s;
   logic [31:0] next_pc_s;
   logic        advance_s;

   // Redirect target select and next-PC choice.
   always_comb begin
      target_s = pc4_s;
      case (pcsource)
         2'b01:   target_s = bpc;
         2'b10:   target_s = rpc;
         2'b11:   target_s = jpc;
         default: target_s = pc4_s;
      endcase
      redirect_s = (pcsource != 2'b00);
      pc4_s      = pc_q + 32'd4;
      if (pend_valid_q) begin
         next_pc_s = pend_pc_q;
      end else if (redirect_s) begin
         next_pc_s = target_s;
      end else begin
         next_pc_s = pc4_s;
      end
   end

   // Next-state, handshake and delivery outputs.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;
      hold_d       = hold_q;
      advance_s    = 1'b0;
      imem_req     = 1'b0;
      ins          = NOP_WORD;
      ins_valid    = 1'b0;
      case (state_q)
         ST_RUN: begin
            // imem_req drops while clr is held even though the state reads RUN.
            imem_req = !clr;
            if (imem_ready && !clr) begin
               ins       = imem_rdata;
               ins_valid = 1'b1;
               if (wpcir) begin
                  advance_s = 1'b1;
               end else begin
                  hold_d  = imem_rdata;
                  state_d = ST_HOLD;
               end
            end else begin
               ins       = NOP_WORD;
               ins_valid = 1'b0;
            end
         end
         ST_HOLD: begin
            ins       = hold_q;
            ins_valid = 1'b1;
            if (wpcir) begin
               advance_s = 1'b1;
               state_d   = ST_RUN;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      // A redirect raised on the delivering cycle is consumed directly by next_pc_s.
      if (advance_s) begin
         pc_d         = next_pc_s;
         pend_valid_d = 1'b0;
      end else if (!pend_valid_q && redirect_s) begin
         pend_pc_d    = target_s;
         pend_valid_d = 1'b1;
      end else begin
         pend_valid_d = pend_valid_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         pend_pc_q    <= 32'h0000_0000;
         pend_valid_q <= 1'b0;
         hold_q       <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
         hold_q       <= hold_d;
      end
   end

   assign pc        = pc_q;
   assign pc4       = pc4_s;
   assign imem_addr = pc_q;

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed bench for pipeif_fetch: reset, wait states, HOLD, redirects, wrap, reset mid-HOLD.
module tb_pipeif_fetch;

   logic        clk = 1'b0;
   logic        clr;
   logic        wpcir;
   logic [1:0]  pcsource;
   logic [31:0] bpc, rpc, jpc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc, pc4, ins;
   logic        ins_valid;

   int total = 0;
   int bad   = 0;

   pipeif_fetch dut (
      .clk(clk), .clr(clr), .wpcir(wpcir), .pcsource(pcsource),
      .bpc(bpc), .rpc(rpc), .jpc(jpc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .pc(pc), .pc4(pc4), .ins(ins), .ins_valid(ins_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   initial begin
      clr = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
      bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
      imem_ready = 1'b1; imem_rdata = 32'h0;
      #2;
      check("rst_pc", pc, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'h0);
      step();
      clr = 1'b0;
      #1;
      check("rel_req", {31'b0, imem_req}, 32'h1);

      // Zero-wait fetches at 0 and 4
      for (int i = 0; i < 2; i++) begin
         imem_rdata = 32'h1000_0000 + i;
         #1;
         check("seq_pc", pc, 32'h4 * i);
         check("seq_pc4", pc4, 32'h4 * i + 32'h4);
         check("seq_ins", ins, 32'h1000_0000 + i);
         check("seq_valid", {31'b0, ins_valid}, 32'h1);
         step();
      end

      // Two wait states at pc=8
      for (int i = 0; i < 2; i++) begin
         imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
         #1;
         check("wait_pc", pc, 32'h8);
         check("wait_addr", imem_addr, 32'h8);
         check("wait_ins", ins, 32'h0);
         check("wait_valid", {31'b0, ins_valid}, 32'h0);
         step();
      end
      imem_ready = 1'b1; imem_rdata = 32'h2002_0005;
      #1;
      check("wait_deliver", ins, 32'h2002_0005);
      check("wait_pc_hold", pc, 32'h8);
      step();
      check("after_wait_pc", pc, 32'hC);
      imem_rdata = 32'h0000_000C;
      step();
      check("pc_10", pc, 32'h10);

      // Stall at pc=10 -> HOLD for three cycles
      imem_rdata = 32'h8C43_0000; wpcir = 1'b0;
      #1;
      check("stall_ins", ins, 32'h8C43_0000);
      check("stall_req", {31'b0, imem_req}, 32'h1);
      step();
      for (int i = 0; i < 2; i++) begin
         imem_rdata = 32'h5555_5555; imem_ready = 1'b0;
         #1;
         check("hold_req", {31'b0, imem_req}, 32'h0);
         check("hold_ins", ins, 32'h8C43_0000);
         check("hold_valid", {31'b0, ins_valid}, 32'h1);
         check("hold_pc", pc, 32'h10);
         step();
      end
      wpcir = 1'b1;
      step();
      check("unhold_pc", pc, 32'h14);
      imem_ready = 1'b1;
      #1;
      check("unhold_req", {31'b0, imem_req}, 32'h1);
      step();
      step();
      step();
      check("pc_20", pc, 32'h20);

      // Redirect raised while waiting at 0x20, then withdrawn
      imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h100;
      step();
      pcsource = 2'b00; bpc = 32'h0;
      step();
      imem_ready = 1'b1; imem_rdata = 32'hAAAA_0020;
      #1;
      check("slot_ins", ins, 32'hAAAA_0020);
      check("slot_pc", pc, 32'h20);
      step();
      check("redir_pc", pc, 32'h100);

      // Simultaneous jump with delivery
      pcsource = 2'b11; jpc = 32'h400;
      step();
      check("jump_pc", pc, 32'h400);
      pcsource = 2'b00;
      step();
      check("no_pend_pc", pc, 32'h404);

      // Register jump to the top of memory, then wrap
      pcsource = 2'b10; rpc = 32'hFFFF_FFFC;
      step();
      check("top_pc", pc, 32'hFFFF_FFFC);
      pcsource = 2'b00;
      #1;
      check("top_pc4", pc4, 32'h0);
      step();
      check("wrap_pc", pc, 32'h0);
      step();
      check("pc_4", pc, 32'h4);

      // Pending redirect, then HOLD, then reset
      imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h200;
      step();
      pcsource = 2'b00; imem_ready = 1'b1; wpcir = 1'b0;
      step();
      #1;
      check("pre_rst_req", {31'b0, imem_req}, 32'h0);
      clr = 1'b1;
      #1;
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_req", {31'b0, imem_req}, 32'h0);
      step();
      clr = 1'b0; wpcir = 1'b1; imem_rdata = 32'h1234_5678;
      #1;
      check("post_rst_req", {31'b0, imem_req}, 32'h1);
      check("post_rst_ins", ins, 32'h1234_5678);
      step();
      check("post_rst_pc", pc, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
